// File: rtl/fixed_pkg.sv
// rtl/fixed_pkg.sv - shared Q5.11 defaults, limits and multiplier state encoding
package fixed_pkg;

  // Default operand/result width and fractional bit count (Q5.11)
  localparam int N = 16;
  localparam int F = 11;

  // Representable extremes and the value 1.0 in the default format
  localparam logic [N-1:0] Q_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] Q_MIN = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] Q_ONE = N'(1 << F);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder.sv
// rtl/adder.sv - n-bit unsigned adder used for the multiplier accumulate step
module adder #(
  parameter int n = 32
) (
  input  logic [n-1:0] a_i,
  input  logic [n-1:0] b_i,
  output logic [n-1:0] sum_o
);

  // Carry out is dropped: callers size n so the sum never exceeds it
  assign sum_o = a_i + b_i;

endmodule

// File: rtl/fixed_multiplier.sv
// rtl/fixed_multiplier.sv - sequential signed Qn-f.f shift-and-add multiplier (FIXMUL_SAT_EN selects saturation)
module fixed_multiplier
  import fixed_pkg::*;
#(
  parameter int n = N,
  parameter int f = F
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] result
);

  localparam int CW = $clog2(n);
  localparam logic [2*n-1:0] HALF = (2*n)'(1) << (f - 1);

  state_t         state_q;
  logic [n-1:0]   mcand_q;
  logic [n-1:0]   mult_q;
  logic           sign_q;
  logic [2*n-1:0] acc_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q;
  logic           done_q;
  logic [n-1:0]   result_q;

  logic [n-1:0]   a_mag;
  logic [n-1:0]   b_mag;
  logic [2*n-1:0] pp;
  logic [2*n-1:0] acc_d;
  logic [2*n-1:0] mag;
  logic [2*n-1:0] val;
  logic [n-1:0]   result_d;
  logic           last_iter;

  // Magnitudes are n-bit unsigned so the most negative operand stays representable
  assign a_mag = a[n-1] ? (~a + 1'b1) : a;
  assign b_mag = b[n-1] ? (~b + 1'b1) : b;

  // Partial product for the multiplier bit retired this cycle
  assign pp = mult_q[0] ? ({{n{1'b0}}, mcand_q} << cnt_q) : '0;

  adder #(
    .n(2*n)
  ) u_acc (
    .a_i  (acc_q),
    .b_i  (pp),
    .sum_o(acc_d)
  );

  assign last_iter = (cnt_q == CW'(n - 1));

  // Round the final magnitude half away from zero, then reapply the sign
  assign mag = (acc_d + HALF) >> f;
  assign val = sign_q ? (~mag + 1'b1) : mag;

  // Only the low n bits of the signed value form the result
  logic unused_val_hi;
  assign unused_val_hi = ^val[2*n-1:n];

`ifdef FIXMUL_SAT_EN
  localparam logic [2*n-1:0] POS_LIMIT = (2*n)'({1'b0, {(n-1){1'b1}}});
  localparam logic [2*n-1:0] NEG_LIMIT = (2*n)'({1'b1, {(n-1){1'b0}}});

  // Clamp magnitudes that cannot be represented with the product's sign
  always_comb begin
    result_d = val[n-1:0];
    if (!sign_q && (mag > POS_LIMIT)) begin
      result_d = {1'b0, {(n-1){1'b1}}};
    end else if (sign_q && (mag > NEG_LIMIT)) begin
      result_d = {1'b1, {(n-1){1'b0}}};
    end
  end
`else
  // Wrap: keep the low n bits with no clamping
  always_comb begin
    result_d = val[n-1:0];
  end
`endif

  // Control FSM: capture operands, retire one multiplier bit per cycle, publish result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mult_q   <= '0;
      sign_q   <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            mcand_q <= a_mag;
            mult_q  <= b_mag;
            sign_q  <= a[n-1] ^ b[n-1];
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          acc_q  <= acc_d;
          mult_q <= mult_q >> 1;
          cnt_q  <= cnt_q + 1'b1;
          if (last_iter) begin
            result_q <= result_d;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_fixed_multiplier.sv
// tb/tb_fixed_multiplier.sv - directed self-checking bench for fixed_multiplier (FIXMUL_SAT_EN aware)
module tb_fixed_multiplier;
  import fixed_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;

  int errors = 0;
  int checks = 0;

  fixed_multiplier #(
    .n(16),
    .f(11)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One multiply: start for one cycle, wait for done, check result, latency and pulse width
  task automatic do_mul(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] ev);
    int lat;
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 16'hDEAD;
    b = 16'hBEEF;
    lat = 1;
    check({tag, " busy"}, busy, 1);
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, 17);
    check({tag, " result"}, result, ev);
    @(negedge clk);
    check({tag, " done width"}, done, 0);
    check({tag, " held"}, result, ev);
  endtask

  initial begin
    int dones[$];
    int lat;
    int seen;

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset result", result, 0);
    rst = 1'b0;

    do_mul("pos*pos", 16'h0C00, 16'h0C00, 16'h1200);
    do_mul("neg*pos", 16'hF400, 16'h0C00, 16'hEE00);
    do_mul("neg*neg", 16'hF400, 16'hF400, 16'h1200);
    do_mul("round half", 16'h0001, 16'h0400, 16'h0001);
    do_mul("round half neg", 16'hFFFF, 16'h0400, 16'hFFFF);
    do_mul("round quarter", 16'h0001, 16'h0200, 16'h0000);
`ifdef FIXMUL_SAT_EN
    do_mul("ovf 8*4", 16'h4000, 16'h2000, 16'h7FFF);
    do_mul("ovf min*-1", 16'h8000, 16'hF800, 16'h7FFF);
`else
    do_mul("ovf 8*4", 16'h4000, 16'h2000, 16'h0000);
    do_mul("ovf min*-1", 16'h8000, 16'hF800, 16'h8000);
`endif
    do_mul("one*one", Q_ONE, Q_ONE, 16'h0800);

    // Start held high: a product every 17 cycles
    @(negedge clk);
    a = 16'h1000;
    b = 16'h0C00;
    start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done) begin
        dones.push_back(c);
        check("b2b result", result, 16'h1800);
      end
    end
    start = 1'b0;
    check("b2b count", dones.size(), 3);
    if (dones.size() >= 3) begin
      check("b2b first", dones[0], 17);
      check("b2b second", dones[1], 34);
      check("b2b third", dones[2], 51);
    end
    lat = 0;
    while (busy && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b drain", busy, 0);
    repeat (2) @(negedge clk);

    // Start pulsed mid-CALC is ignored
    a = 16'h0C00;
    b = 16'h0C00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    repeat (4) begin
      @(negedge clk);
      lat++;
    end
    a = 16'h4000;
    b = 16'h2000;
    start = 1'b1;
    @(negedge clk);
    lat++;
    start = 1'b0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("mid start latency", lat, 17);
    check("mid start result", result, 16'h1200);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("mid start no second done", seen, 0);
    check("mid start idle", busy, 0);

    // Reset during CALC aborts immediately
    a = 16'h0C00;
    b = 16'h0C00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort result", result, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("abort no done", seen, 0);
    do_mul("after abort", Q_ONE, Q_ONE, 16'h0800);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
